mc_decode_exec: RTL and testbench

MC_DECODE_EXEC -- requirements
Module: mc_decode_exec

---
 rtl/mc_pkg.sv | 41 ++++
 rtl/mc_decode.sv | 37 +++
 rtl/mc_decode_exec.sv | 184 ++++++++++++++++++
 tb/tb_mc_decode_exec.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared opcode/funct constants, class/control encodings and FSM state type
// for the decode/execute unit.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] CLS_ILL = 2'b00;
    localparam logic [1:0] CLS_R   = 2'b01;
    localparam logic [1:0] CLS_J   = 2'b10;
    localparam logic [1:0] CLS_I   = 2'b11;

    localparam logic [4:0] CS_ADD = 5'b10010;
    localparam logic [4:0] CS_SUB = 5'b10001;
    localparam logic [4:0] CS_AND = 5'b10011;
    localparam logic [4:0] CS_OR  = 5'b10100;
    localparam logic [4:0] CS_SLT = 5'b10101;
    localparam logic [4:0] CS_LW  = 5'b11000;
    localparam logic [4:0] CS_SW  = 5'b00100;
    localparam logic [4:0] CS_BEQ = 5'b00010;
    localparam logic [4:0] CS_J   = 5'b00000;
    localparam logic [4:0] CS_ILL = 5'b00000;

    typedef enum logic [3:0] {
        K_ILL, K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_LW, K_SW, K_BEQ, K_J
    } kind_t;

    typedef enum logic [1:0] {
        S_IDLE, S_EXEC, S_MEM, S_DONE
    } state_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: opcode/funct to class, control code and
// an internal operation kind used by the execute stage.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [1:0] o_cls,
    output logic [4:0] o_cs,
    output kind_t      o_kind
);

    // Anything not matched below stays illegal.
    always_comb begin
        o_cls  = CLS_ILL;
        o_cs   = CS_ILL;
        o_kind = K_ILL;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD:  begin o_cls = CLS_R; o_cs = CS_ADD; o_kind = K_ADD; end
                    FN_SUB:  begin o_cls = CLS_R; o_cs = CS_SUB; o_kind = K_SUB; end
                    FN_AND:  begin o_cls = CLS_R; o_cs = CS_AND; o_kind = K_AND; end
                    FN_OR:   begin o_cls = CLS_R; o_cs = CS_OR;  o_kind = K_OR;  end
                    FN_SLT:  begin o_cls = CLS_R; o_cs = CS_SLT; o_kind = K_SLT; end
                    default: ;
                endcase
            end
            OP_LW:   begin o_cls = CLS_I; o_cs = CS_LW;  o_kind = K_LW;  end
            OP_SW:   begin o_cls = CLS_I; o_cs = CS_SW;  o_kind = K_SW;  end
            OP_BEQ:  begin o_cls = CLS_I; o_cs = CS_BEQ; o_kind = K_BEQ; end
            OP_J:    begin o_cls = CLS_J; o_cs = CS_J;   o_kind = K_J;   end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_decode_exec.sv
// Multi-cycle decode/execute unit: accepts one instruction, computes ALU,
// branch and writeback results, performs an optional memory access.
module mc_decode_exec
    import mc_pkg::*;
#(
    parameter int DW        = 32,
    parameter int OFF_SHIFT = 2,
    parameter int PC_STEP   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   instr,
    input  logic [DW-1:0] pc,
    input  logic [DW-1:0] rs_val,
    input  logic [DW-1:0] rt_val,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    cls,
    output logic [4:0]    cs,
    output logic          illegal,
    output logic [DW-1:0] alu,
    output logic          wb_en,
    output logic [4:0]    wb_reg,
    output logic [DW-1:0] wb_data,
    output logic [DW-1:0] next_pc,
    output logic          taken
);

    localparam logic [DW-1:0] JMASK = DW'(64'h0FFF_FFFF);

    state_t        r_state;
    logic [31:0]   r_instr;
    logic [DW-1:0] r_pc, r_rs, r_rt;
    logic          r_mem_req, r_mem_we, r_out_valid, r_illegal, r_wb_en, r_taken;
    logic [DW-1:0] r_mem_addr, r_mem_wdata, r_alu, r_wb_data, r_next_pc;
    logic [1:0]    r_cls;
    logic [4:0]    r_cs, r_wb_reg;

    logic [1:0]    w_cls;
    logic [4:0]    w_cs, w_wb_reg;
    kind_t         w_kind;
    logic [DW-1:0] w_sext, w_mem_addr, w_pc_seq, w_jmp, w_alu, w_next_pc;
    logic          w_taken, w_wb_en;

    mc_decode u_decode (
        .i_opcode (r_instr[31:26]),
        .i_funct  (r_instr[5:0]),
        .o_cls    (w_cls),
        .o_cs     (w_cs),
        .o_kind   (w_kind)
    );

    assign w_sext     = DW'($signed(r_instr[15:0]));
    assign w_mem_addr = r_rs + (w_sext << OFF_SHIFT);
    assign w_pc_seq   = r_pc + DW'(PC_STEP);
    assign w_jmp      = (w_pc_seq & ~JMASK) | (DW'({r_instr[25:0], 2'b00}) & JMASK);

    always_comb begin
        w_alu     = '0;
        w_next_pc = w_pc_seq;
        w_taken   = 1'b0;
        w_wb_reg  = 5'd0;
        case (w_kind)
            K_ADD:      begin w_alu = r_rs + r_rt; w_wb_reg = r_instr[15:11]; end
            K_SUB:      begin w_alu = r_rs - r_rt; w_wb_reg = r_instr[15:11]; end
            K_AND:      begin w_alu = r_rs & r_rt; w_wb_reg = r_instr[15:11]; end
            K_OR:       begin w_alu = r_rs | r_rt; w_wb_reg = r_instr[15:11]; end
            K_SLT:      begin
                w_alu    = DW'($signed(r_rs) < $signed(r_rt));
                w_wb_reg = r_instr[15:11];
            end
            K_LW:       begin w_alu = w_mem_addr; w_wb_reg = r_instr[20:16]; end
            K_SW:       w_alu = w_mem_addr;
            K_BEQ:      begin
                w_alu   = r_rs - r_rt;
                w_taken = (w_alu == '0);
                if (w_taken) w_next_pc = w_pc_seq + (w_sext << 2);
            end
            K_J:        w_next_pc = w_jmp;
            default:    ;
        endcase
        w_wb_en = (w_wb_reg != 5'd0);
    end

    // Results are latched in EXEC and held through MEM/DONE so the consumer
    // sees stable values; lw load data is the only late update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_instr     <= '0;
            r_pc        <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_out_valid <= 1'b0;
            r_cls       <= '0;
            r_cs        <= '0;
            r_illegal   <= 1'b0;
            r_alu       <= '0;
            r_wb_en     <= 1'b0;
            r_wb_reg    <= '0;
            r_wb_data   <= '0;
            r_next_pc   <= '0;
            r_taken     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_instr <= instr;
                        r_pc    <= pc;
                        r_rs    <= rs_val;
                        r_rt    <= rt_val;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_cls     <= w_cls;
                    r_cs      <= w_cs;
                    r_illegal <= (w_kind == K_ILL);
                    r_alu     <= w_alu;
                    r_wb_en   <= w_wb_en;
                    r_wb_reg  <= w_wb_reg;
                    r_wb_data <= w_alu;
                    r_next_pc <= w_next_pc;
                    r_taken   <= w_taken;
                    if (w_kind == K_LW || w_kind == K_SW) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= (w_kind == K_SW);
                        r_mem_addr  <= w_mem_addr;
                        r_mem_wdata <= r_rt;
                        r_state     <= S_MEM;
                    end else begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_wb_reg != 5'd0) r_wb_data <= mem_rdata;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign out_valid = r_out_valid;
    assign cls       = r_cls;
    assign cs        = r_cs;
    assign illegal   = r_illegal;
    assign alu       = r_alu;
    assign wb_en     = r_wb_en;
    assign wb_reg    = r_wb_reg;
    assign wb_data   = r_wb_data;
    assign next_pc   = r_next_pc;
    assign taken     = r_taken;

endmodule

// File: tb/tb_mc_decode_exec.sv
// Directed self-checking bench for mc_decode_exec with hand-computed vectors.
module tb_mc_decode_exec;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [31:0]   instr;
    logic [DW-1:0] pc, rs_val, rt_val;
    logic          mem_req, mem_we, mem_ack;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic          out_valid, out_ready;
    logic [1:0]    cls;
    logic [4:0]    cs;
    logic          illegal, wb_en, taken;
    logic [DW-1:0] alu, wb_data, next_pc;
    logic [4:0]    wb_reg;

    int checks = 0;
    int errors = 0;
    int reqCycles;

    mc_decode_exec #(.DW(DW), .OFF_SHIFT(2), .PC_STEP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cls       (cls),
        .cs        (cs),
        .illegal   (illegal),
        .alu       (alu),
        .wb_en     (wb_en),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .next_pc   (next_pc),
        .taken     (taken)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offers one instruction in IDLE and returns one cycle later (DUT in EXEC).
    task automatic applyStimulus(input logic [31:0] ins, input logic [DW-1:0] p,
                                 input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                                 input bit keepValid);
        instr    = ins;
        pc       = p;
        rs_val   = rs;
        rt_val   = rt;
        in_valid = 1'b1;
        checkOutput("accept_in_ready", in_ready, 1);
        @(negedge clk);
        if (!keepValid) in_valid = 1'b0;
    endtask

    task automatic releaseOutput();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("release_in_ready", in_ready, 1);
        checkOutput("release_out_valid", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; instr = '0; pc = '0; rs_val = '0; rt_val = '0;
        mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_alu", alu, 0);
        checkOutput("rst_next_pc", next_pc, 0);
        checkOutput("rst_wb_en", wb_en, 0);
        rst = 1'b0;
        @(negedge clk);

        // add r3 = r1 + r2
        applyStimulus(32'h0022_1820, 32'h10, 32'd7, 32'd5, 0);
        checkOutput("add_lat1_out_valid", out_valid, 0);
        checkOutput("add_exec_in_ready", in_ready, 0);
        @(negedge clk);
        checkOutput("add_out_valid", out_valid, 1);
        checkOutput("add_alu", alu, 12);
        checkOutput("add_wb_reg", wb_reg, 3);
        checkOutput("add_wb_en", wb_en, 1);
        checkOutput("add_wb_data", wb_data, 12);
        checkOutput("add_cls", cls, 2'b01);
        checkOutput("add_cs", cs, 5'b10010);
        checkOutput("add_next_pc", next_pc, 32'h14);
        checkOutput("add_illegal", illegal, 0);
        releaseOutput();

        // sub and slt with signed operands
        applyStimulus(32'h0022_1822, 32'h20, 32'd5, 32'd7, 0);
        @(negedge clk);
        checkOutput("sub_alu", alu, 32'hFFFF_FFFE);
        checkOutput("sub_cs", cs, 5'b10001);
        releaseOutput();
        applyStimulus(32'h0022_182A, 32'h20, 32'hFFFF_FFFD, 32'd2, 0);
        @(negedge clk);
        checkOutput("slt_alu", alu, 1);
        checkOutput("slt_cs", cs, 5'b10101);
        releaseOutput();

        // lw r16, 8(r1) with ack after 3 wait cycles
        mem_rdata = 32'h1111_1111;
        applyStimulus(32'h8C30_0008, 32'h30, 32'h100, 32'h0, 0);
        checkOutput("lw_exec_mem_req", mem_req, 0);
        reqCycles = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_req) reqCycles++;
            checkOutput("lw_wait_mem_addr", mem_addr, 32'h120);
            checkOutput("lw_wait_out_valid", out_valid, 0);
        end
        @(negedge clk);
        if (mem_req) reqCycles++;
        checkOutput("lw_mem_we", mem_we, 0);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = '0;
        checkOutput("lw_req_cycles", reqCycles, 4);
        checkOutput("lw_mem_req_drop", mem_req, 0);
        checkOutput("lw_out_valid", out_valid, 1);
        checkOutput("lw_wb_data", wb_data, 32'hDEAD_BEEF);
        checkOutput("lw_wb_reg", wb_reg, 16);
        checkOutput("lw_wb_en", wb_en, 1);
        checkOutput("lw_cs", cs, 5'b11000);
        checkOutput("lw_cls", cls, 2'b11);
        releaseOutput();

        // sw r2, -1(r1): address 0x200 - 4
        applyStimulus(32'hAC22_FFFF, 32'h34, 32'h200, 32'h0000_CAFE, 0);
        @(negedge clk);
        checkOutput("sw_mem_req", mem_req, 1);
        checkOutput("sw_mem_we", mem_we, 1);
        checkOutput("sw_mem_addr", mem_addr, 32'h1FC);
        checkOutput("sw_mem_wdata", mem_wdata, 32'hCAFE);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("sw_out_valid", out_valid, 1);
        checkOutput("sw_wb_en", wb_en, 0);
        checkOutput("sw_cs", cs, 5'b00100);
        releaseOutput();

        // beq taken back to itself, then not taken
        applyStimulus(32'h1022_FFFF, 32'h40, 32'd9, 32'd9, 0);
        @(negedge clk);
        checkOutput("beq_t_taken", taken, 1);
        checkOutput("beq_t_next_pc", next_pc, 32'h40);
        checkOutput("beq_t_wb_en", wb_en, 0);
        checkOutput("beq_t_cs", cs, 5'b00010);
        releaseOutput();
        applyStimulus(32'h1022_FFFF, 32'h40, 32'd9, 32'd8, 0);
        @(negedge clk);
        checkOutput("beq_nt_taken", taken, 0);
        checkOutput("beq_nt_next_pc", next_pc, 32'h44);
        releaseOutput();

        // j: keep upper 4 bits of pc+4, replace the rest
        applyStimulus(32'h0800_0010, 32'h3000_0040, 32'd0, 32'd0, 0);
        @(negedge clk);
        checkOutput("j_next_pc", next_pc, 32'h3000_0040);
        checkOutput("j_cls", cls, 2'b10);
        checkOutput("j_wb_en", wb_en, 0);
        releaseOutput();

        // illegal opcode and add to r0
        applyStimulus(32'hFC00_0000, 32'h80, 32'd1, 32'd2, 0);
        @(negedge clk);
        checkOutput("ill_out_valid", out_valid, 1);
        checkOutput("ill_illegal", illegal, 1);
        checkOutput("ill_cls", cls, 2'b00);
        checkOutput("ill_cs", cs, 5'b00000);
        checkOutput("ill_wb_en", wb_en, 0);
        checkOutput("ill_next_pc", next_pc, 32'h84);
        releaseOutput();
        applyStimulus(32'h0022_0020, 32'h90, 32'd7, 32'd5, 0);
        @(negedge clk);
        checkOutput("add_r0_wb_en", wb_en, 0);
        checkOutput("add_r0_alu", alu, 12);
        releaseOutput();

        // backpressure with in_valid left high and a different instruction
        applyStimulus(32'h0022_1820, 32'h100, 32'd7, 32'd5, 1);
        instr  = 32'h0022_1822;
        rs_val = 32'd100;
        rt_val = 32'd1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_alu", alu, 12);
            checkOutput("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        checkOutput("bp_final_alu", alu, 12);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("bp_back_idle", in_ready, 1);
        @(negedge clk);
        checkOutput("bp_no_accept", in_ready, 1);

        // reset while waiting in MEM
        applyStimulus(32'h8C30_0008, 32'h200, 32'h100, 32'h0, 0);
        @(negedge clk);
        checkOutput("rmem_mem_req", mem_req, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rmem_req_async", mem_req, 0);
        checkOutput("rmem_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("rmem_ack_in_ready", in_ready, 1);
        checkOutput("rmem_ack_out_valid", out_valid, 0);
        checkOutput("rmem_ack_mem_req", mem_req, 0);
        checkOutput("rmem_ack_wb_data", wb_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
